// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined ALU adder-subtractor.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package alu_pkg;

   localparam int ALU_WIDTH_DEFAULT = 16;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

   // Signed saturation bound: min when sign is set, max otherwise (width <= 64).
   function automatic logic [63:0] sat_value(input logic sign, input int width);
      logic [63:0] msb_only;
      msb_only = 64'd1 << (width - 1);
      return sign ? msb_only : (msb_only - 64'd1);
   endfunction

endpackage

// File: rtl/alu_add_segment.sv
// SEG-bit ripple-carry slice of the pipelined adder.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage decides when to register.
module alu_add_segment #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined add/sub with cout/ovf/zero/neg flags; ALU_ADDSUB_SAT_EN adds a per-beat sat input.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle.
// Backpressure: valid/ready with bubble collapse; output holds while out_valid && !out_ready.
module alu_addsub_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH_DEFAULT,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
`ifdef ALU_ADDSUB_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Index k of *_in is what stage k consumes; *_q is what stage k holds.
   logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
   logic [STAGES-1:0]            c_in, c_d, c_q, v_in, v_q, adv;
`ifdef ALU_ADDSUB_SAT_EN
   logic [STAGES-1:0]            sat_in, sat_q;
   logic [63:0]                  sat_full;
`endif

   flags_t           flags_d, flags_q;
   logic [WIDTH-1:0] res_d;
   logic             a_msb, b_msb;

   assign a_in[0] = a;
   assign b_in[0] = sub ? ~b : b;
   assign s_in[0] = '0;
   assign c_in[0] = sub ? ~cin : cin;
   assign v_in[0] = in_valid;
`ifdef ALU_ADDSUB_SAT_EN
   assign sat_in[0] = sat;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);
      logic [SEG-1:0] seg_s;

      if (k > 0) begin : g_link
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign v_in[k] = v_q[k-1];
`ifdef ALU_ADDSUB_SAT_EN
         assign sat_in[k] = sat_q[k-1];
`endif
      end

      if (k == LAST) begin : g_adv_last
         assign adv[k] = !v_q[k] || out_ready;
      end else begin : g_adv_mid
         assign adv[k] = !v_q[k] || adv[k+1];
      end

      alu_add_segment #(.SEG(SEG)) u_seg (
         .a  (a_in[k][k*SEG +: SEG]),
         .b  (b_in[k][k*SEG +: SEG]),
         .ci (c_in[k]),
         .s  (seg_s),
         .co (c_d[k])
      );

      assign s_d[k] = (s_in[k] & ~SEG_MASK) | (WIDTH'(seg_s) << (k * SEG));

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
`ifdef ALU_ADDSUB_SAT_EN
            sat_q[k] <= 1'b0;
`endif
         end else if (adv[k]) begin
            v_q[k] <= v_in[k];
            // Payload only moves with a real beat so bubbles leave outputs untouched.
            if (v_in[k]) begin
               a_q[k] <= a_in[k];
               b_q[k] <= b_in[k];
               s_q[k] <= (k == LAST) ? res_d : s_d[k];
               c_q[k] <= c_d[k];
`ifdef ALU_ADDSUB_SAT_EN
               sat_q[k] <= sat_in[k];
`endif
            end
         end
      end
   end

   assign a_msb = a_in[LAST][WIDTH-1];
   assign b_msb = b_in[LAST][WIDTH-1];
`ifdef ALU_ADDSUB_SAT_EN
   assign sat_full = sat_value(a_msb, WIDTH);
`endif

   always_comb begin
      res_d        = s_d[LAST];
      flags_d.cout = c_d[LAST];
      flags_d.ovf  = (a_msb == b_msb) && (s_d[LAST][WIDTH-1] != a_msb);
`ifdef ALU_ADDSUB_SAT_EN
      if (sat_in[LAST] && flags_d.ovf) begin
         res_d = sat_full[WIDTH-1:0];
      end
`endif
      flags_d.zero = ~|res_d;
      flags_d.neg  = res_d[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else if (adv[LAST] && v_in[LAST]) begin
         flags_q <= flags_d;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = flags_q.cout;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;

   // Last-stage operand copies are never consumed; keep them out of lint noise.
   logic unused_ok;
`ifdef ALU_ADDSUB_SAT_EN
   assign unused_ok = ^{a_q[LAST], b_q[LAST], c_q[LAST], sat_q[LAST], sat_full};
`else
   assign unused_ok = ^{a_q[LAST], b_q[LAST], c_q[LAST]};
`endif

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Directed and sweep bench for alu_addsub_pipe (WIDTH=16).
module tb_alu_addsub_pipe;

   localparam int N_SWEEP = 1000;

   typedef struct {
      logic [19:0] exp;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        sweep_go = 1'b0;

   always #5 clk = ~clk;

   // Main directed DUT, STAGES=2
   logic        d_in_valid, d_in_ready, d_sub, d_cin, d_sat;
   logic        d_out_valid, d_out_ready, d_cout, d_ovf, d_zero, d_neg;
   logic [15:0] d_a, d_b, d_sum;

   alu_addsub_pipe #(.WIDTH(16), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (d_in_valid),
      .in_ready  (d_in_ready),
      .a         (d_a),
      .b         (d_b),
      .sub       (d_sub),
      .cin       (d_cin),
`ifdef ALU_ADDSUB_SAT_EN
      .sat       (d_sat),
`endif
      .out_valid (d_out_valid),
      .out_ready (d_out_ready),
      .sum       (d_sum),
      .cout      (d_cout),
      .ovf       (d_ovf),
      .zero      (d_zero),
      .neg       (d_neg)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] ref_alu(input logic [15:0] ra, input logic [15:0] rb,
                                           input logic rsub, input logic rcin, input logic rsat);
      logic [15:0] be;
      logic [16:0] t;
      logic [15:0] s;
      logic        o;
      be = rsub ? ~rb : rb;
      t  = {1'b0, ra} + {1'b0, be} + {16'd0, (rsub ? ~rcin : rcin)};
      s  = t[15:0];
      o  = (ra[15] == be[15]) && (s[15] != ra[15]);
      if (rsat && o) s = ra[15] ? 16'h8000 : 16'h7FFF;
      return {s, t[16], o, (s == 16'd0), s[15]};
   endfunction

   // One beat through the empty main pipe; checks latency and {sum,cout,ovf,zero,neg}.
   task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vsub, input logic vcin, input logic vsat,
                          input logic [19:0] exp);
      int lat;
      d_out_ready = 1'b1;
      d_a = va; d_b = vb; d_sub = vsub; d_cin = vcin; d_sat = vsat;
      d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      lat = 1;
      while (!d_out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd2);
      chk({tag, "_res"}, 64'({d_sum, d_cout, d_ovf, d_zero, d_neg}), 64'(exp));
   endtask

   // Sweep DUTs: STAGES in {1,2,4,16}, continuous random stream, out_ready held high.
   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
      logic        iv, ir, sb, ci, st, ov, co, of, zo, ng;
      logic [15:0] ra, rb, sm;
      bit          done;
      exp_t        q[$];

      alu_addsub_pipe #(.WIDTH(16), .STAGES(ST)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (ra),
         .b         (rb),
         .sub       (sb),
         .cin       (ci),
`ifdef ALU_ADDSUB_SAT_EN
         .sat       (st),
`endif
         .out_valid (ov),
         .out_ready (1'b1),
         .sum       (sm),
         .cout      (co),
         .ovf       (of),
         .zero      (zo),
         .neg       (ng)
      );

      initial begin
         int   sent;
         int   recv;
         logic fire;
         exp_t e;
         iv = 1'b0; ra = '0; rb = '0; sb = 1'b0; ci = 1'b0; st = 1'b0;
         wait (sweep_go);
         sent = 0;
         recv = 0;
         for (int cyc = 0; cyc < N_SWEEP + 100 && recv < N_SWEEP; cyc++) begin
            if (sent < N_SWEEP) begin
               iv = 1'b1;
               ra = 16'($urandom);
               rb = 16'($urandom);
               sb = 1'($urandom);
               ci = 1'($urandom);
`ifdef ALU_ADDSUB_SAT_EN
               st = 1'($urandom);
`endif
            end else begin
               iv = 1'b0;
            end
            #1;
            fire = iv && ir;
            if (fire) q.push_back('{ref_alu(ra, rb, sb, ci, st), cyc});
            if (ov) begin
               if (q.size() == 0) begin
                  chk($sformatf("sw%0d_extra", ST), 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("sw%0d_res", ST), 64'({sm, co, of, zo, ng}), 64'(e.exp));
                  chk($sformatf("sw%0d_lat", ST), 64'(cyc - e.cyc), 64'(ST));
               end
               recv++;
            end
            if (fire) sent++;
            @(posedge clk);
            #1;
         end
         chk($sformatf("sw%0d_count", ST), 64'(recv), 64'(N_SWEEP));
         done = 1'b1;
      end
   end

   initial begin
      logic      pat [4];
      int        sent;
      int        got;
      int        occ;
      int        stale;
      logic      fire_in;
      logic      fire_out;
      logic      all_done;

      d_in_valid = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_cin = 1'b0; d_sat = 1'b0;
      d_out_ready = 1'b1;
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_out", 64'({d_out_valid, d_sum, d_cout, d_ovf, d_zero, d_neg}), 64'd0);
      chk("reset_in_ready", 64'(d_in_ready), 64'd1);

      // Directed vectors: expected = {sum, cout, ovf, zero, neg}
      run_vec("add_3_4",      16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, {16'h0007, 4'b0000});
      run_vec("add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h8000, 4'b0101});
      run_vec("sub_zero",     16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, {16'h0000, 4'b1010});
      run_vec("sub_borrow",   16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, {16'hFFFF, 4'b0001});
      run_vec("sub_min_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, {16'h7FFF, 4'b1100});
      run_vec("add_cin_wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, {16'h0000, 4'b1010});
      run_vec("sub_bin",      16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, {16'h0001, 4'b1000});
      run_vec("add_min_min",  16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, {16'h0000, 4'b1110});
`ifdef ALU_ADDSUB_SAT_EN
      run_vec("sat_pos",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h7FFF, 4'b0100});
      run_vec("sat_neg",      16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, {16'h8000, 4'b1101});
      run_vec("sat_noovf",    16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, {16'h0007, 4'b0000});
`endif
      d_sat = 1'b0;

      // Backpressure stream: 8 beats A=B=i, out_ready cycling 1,0,0,1
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      sent = 0; got = 0; occ = 0;
      tick();
      for (int c = 0; c < 200 && got < 8; c++) begin
         d_out_ready = pat[c % 4];
         d_in_valid  = (sent < 8);
         d_a = 16'(sent);
         d_b = 16'(sent);
         d_sub = 1'b0;
         d_cin = 1'b0;
         #1;
         chk("bp_in_ready", 64'(d_in_ready), 64'((occ < 2) || d_out_ready));
         if (d_out_valid) chk("bp_sum", 64'(d_sum), 64'(2 * got));
         fire_in  = d_in_valid && d_in_ready;
         fire_out = d_out_valid && d_out_ready;
         @(posedge clk);
         #1;
         if (fire_in) begin sent++; occ++; end
         if (fire_out) begin got++; occ--; end
      end
      d_in_valid = 1'b0;
      d_out_ready = 1'b1;
      chk("bp_count", 64'(got), 64'd8);
      tick(); tick();

      // Reset with two beats in flight
      d_a = 16'h0011; d_b = 16'h0022; d_in_valid = 1'b1;
      tick();
      d_a = 16'h0033; d_b = 16'h0044;
      tick();
      d_in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_out", 64'({d_out_valid, d_sum, d_cout, d_ovf, d_zero, d_neg}), 64'd0);
      #1;
      chk("rst_mid_in_ready", 64'(d_in_ready), 64'd1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (d_out_valid) stale++;
      end
      chk("rst_no_stale", 64'(stale), 64'd0);

      // Random sweep across pipeline depths
      sweep_go = 1'b1;
      all_done = 1'b0;
      for (int c = 0; c < 5000 && !all_done; c++) begin
         tick();
         all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
      end
      chk("sweep_done", 64'(all_done), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
